baud_tick_generator: RTL and testbench

//  Parametrised UART baud/oversample tick source for the lab2 UART transmitter and receiver.

---
 rtl/baud_pkg.sv | 26 ++
 rtl/baud_phase_accum.sv | 49 ++++
 rtl/baud_tick_generator.sv | 117 +++++++++++
 tb/tb_baud_tick_generator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants for the UART baud tick generator: supported baud rates
// and a constant-foldable ceil(log2) helper used to size counters.
package baud_pkg;

   localparam int unsigned MAX_BAUD = 32'd115200;

   localparam int unsigned BAUD_TABLE [0:7] = '{
      32'd300, 32'd1200, 32'd4800, 32'd9600,
      32'd19200, 32'd38400, 32'd57600, 32'd115200
   };

   // Smallest r with 2**r >= value; usable in parameter expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            r = 32'(i) + 32'd1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/baud_phase_accum.sv
// Phase accumulator that adds inc each enabled clock and wraps at MODULUS.
// tick is combinational so the parent can register it on the crossing edge.
module baud_phase_accum #(
   parameter int unsigned ACC_W   = 32'd27,
   parameter int unsigned MODULUS = 32'd50_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [ACC_W-1:0] inc,
   output logic             tick
);

   localparam logic [ACC_W-1:0] MOD_V = ACC_W'(MODULUS);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] nxt_s;

   // Next phase: clear beats enable; a crossing subtracts the modulus and ticks.
   always_comb begin
      nxt_s = acc_q + inc;
      acc_d = acc_q;
      tick  = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         if (nxt_s >= MOD_V) begin
            acc_d = nxt_s - MOD_V;
            tick  = 1'b1;
         end else begin
            acc_d = nxt_s;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Phase register.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/baud_tick_generator.sv
// UART baud/oversample tick source: DDS phase accumulator plus sample-index
// counter, with registered sample, bit and mid-bit pulses.
module baud_tick_generator
   import baud_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000,
   parameter int unsigned OVERSAMPLE  = 32'd16,
   parameter int unsigned ACC_W       = clog2(CLK_FREQ_HZ) + 32'd1,
   localparam int unsigned IDX_W      = clog2(OVERSAMPLE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       baud_select,
   input  logic             resync,
   output logic             sample_ENABLE,
   output logic             bit_tick,
   output logic             mid_bit_tick,
   output logic [IDX_W-1:0] sample_index
);

   localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(OVERSAMPLE / 32'd2);

   if (((OVERSAMPLE & (OVERSAMPLE - 32'd1)) != 32'd0) ||
       (OVERSAMPLE < 32'd4) || (OVERSAMPLE > 32'd32)) begin : g_bad_oversample
      $error("baud_tick_generator: OVERSAMPLE must be a power of 2 in 4..32");
   end
   if (CLK_FREQ_HZ < OVERSAMPLE * MAX_BAUD) begin : g_bad_clk
      $error("baud_tick_generator: CLK_FREQ_HZ too low for OVERSAMPLE*115200");
   end

   logic [2:0]       sel_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             sample_q;
   logic             sample_d;
   logic             bit_q;
   logic             bit_d;
   logic             mid_q;
   logic             mid_d;
   logic             clear_s;
   logic             tick_s;
   logic [ACC_W-1:0] inc_s;

   // A rate change and a resync collapse into one clear of phase and index.
   always_comb begin
      clear_s = (baud_select != sel_q) | resync;
   end

   // Phase increment per clock for the currently latched rate.
   always_comb begin
      case (sel_q)
         3'd0:    inc_s = ACC_W'(BAUD_TABLE[0] * OVERSAMPLE);
         3'd1:    inc_s = ACC_W'(BAUD_TABLE[1] * OVERSAMPLE);
         3'd2:    inc_s = ACC_W'(BAUD_TABLE[2] * OVERSAMPLE);
         3'd3:    inc_s = ACC_W'(BAUD_TABLE[3] * OVERSAMPLE);
         3'd4:    inc_s = ACC_W'(BAUD_TABLE[4] * OVERSAMPLE);
         3'd5:    inc_s = ACC_W'(BAUD_TABLE[5] * OVERSAMPLE);
         3'd6:    inc_s = ACC_W'(BAUD_TABLE[6] * OVERSAMPLE);
         3'd7:    inc_s = ACC_W'(BAUD_TABLE[7] * OVERSAMPLE);
         default: inc_s = ACC_W'(BAUD_TABLE[7] * OVERSAMPLE);
      endcase
   end

   baud_phase_accum #(
      .ACC_W   (ACC_W),
      .MODULUS (CLK_FREQ_HZ)
   ) u_accum (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear_s),
      .enable (enable),
      .inc    (inc_s),
      .tick   (tick_s)
   );

   // Sample index and pulse decode; pulses reflect the index after the increment.
   always_comb begin
      idx_d    = idx_q;
      sample_d = 1'b0;
      bit_d    = 1'b0;
      mid_d    = 1'b0;
      if (clear_s) begin
         idx_d = '0;
      end else if (tick_s) begin
         idx_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
         sample_d = 1'b1;
         bit_d    = (idx_d == '0);
         mid_d    = (idx_d == HALF_IDX);
      end else begin
         idx_d = idx_q;
      end
   end

   // Rate latch, index counter and output pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q    <= baud_select;
         idx_q    <= '0;
         sample_q <= 1'b0;
         bit_q    <= 1'b0;
         mid_q    <= 1'b0;
      end else begin
         sel_q    <= baud_select;
         idx_q    <= idx_d;
         sample_q <= sample_d;
         bit_q    <= bit_d;
         mid_q    <= mid_d;
      end
   end

   assign sample_ENABLE = sample_q;
   assign bit_tick      = bit_q;
   assign mid_bit_tick  = mid_q;
   assign sample_index  = idx_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench: directed scenarios plus random stimulus, compared each
// cycle against a model that counts ticks as floor(n*INC/F) crossings.
module tb_baud_tick_generator;

   localparam longint F_HZ = 64'd50_000_000;
   localparam int      OS   = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic [2:0] baud_select = 3'd7;
   logic       resync = 1'b0;
   logic       sample_ENABLE;
   logic       bit_tick;
   logic       mid_bit_tick;
   logic [3:0] sample_index;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int     m_sel = 7;
   longint m_n = 0;
   longint m_s = 0;
   logic   m_se, m_bit, m_mid;
   logic   prev_se = 1'b0;

   baud_tick_generator dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .baud_select   (baud_select),
      .resync        (resync),
      .sample_ENABLE (sample_ENABLE),
      .bit_tick      (bit_tick),
      .mid_bit_tick  (mid_bit_tick),
      .sample_index  (sample_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint rate_of(input int sel);
      case (sel)
         0: return 64'd300;
         1: return 64'd1200;
         2: return 64'd4800;
         3: return 64'd9600;
         4: return 64'd19200;
         5: return 64'd38400;
         6: return 64'd57600;
         default: return 64'd115200;
      endcase
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      longint inc;
      @(posedge clk);
      m_se = 1'b0; m_bit = 1'b0; m_mid = 1'b0;
      if (reset) begin
         m_sel = int'(baud_select); m_n = 0; m_s = 0;
      end else if (int'(baud_select) != m_sel) begin
         m_sel = int'(baud_select); m_n = 0; m_s = 0;
      end else if (resync) begin
         m_n = 0; m_s = 0;
      end else if (enable) begin
         inc = rate_of(m_sel) * OS;
         m_n++;
         if ((m_n * inc) / F_HZ != ((m_n - 1) * inc) / F_HZ) begin
            m_s++;
            m_se  = 1'b1;
            m_bit = (m_s % OS) == 0;
            m_mid = (m_s % OS) == OS / 2;
         end
      end
      #1;
      chk("sample_ENABLE", sample_ENABLE, m_se);
      chk("bit_tick", bit_tick, m_bit);
      chk("mid_bit_tick", mid_bit_tick, m_mid);
      chk("sample_index", sample_index, m_s % OS);
      chk("bit_implies_se", bit_tick & ~sample_ENABLE, 0);
      chk("se_consecutive", prev_se & sample_ENABLE, 0);
      prev_se = sample_ENABLE;
   endtask

   initial begin
      int k, cnt, last, sp, idx_hold, pulses, mids, bits, sel_r;
      bit found;

      // 1: reset held 5 clk, outputs 0, first tick on edge 28
      reset = 1'b1; baud_select = 3'd7; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("reset_outputs", {sample_ENABLE, bit_tick, mid_bit_tick, sample_index}, 0);
      end
      reset = 1'b0;
      found = 1'b0; k = 0;
      for (int i = 1; i <= 100 && !found; i++) begin
         step();
         if (sample_ENABLE) begin found = 1'b1; k = i; end
      end
      chk("first_tick_edge", k, 28);

      // 2: 9600 baud, tick count and spacing
      baud_select = 3'd3;
      step();
      cnt = 0; last = -1; bits = 0; mids = 0;
      for (int i = 1; i <= 20000; i++) begin
         step();
         if (sample_ENABLE) begin
            if (last >= 0) begin
               sp = i - last;
               chk("spacing_9600", (sp == 325 || sp == 326) ? 1 : 0, 1);
            end
            last = i; cnt++;
         end
         if (bit_tick) bits++;
         if (mid_bit_tick) mids++;
      end
      chk("count_9600", cnt, (20000 * 153600) / F_HZ);
      chk("bits_9600", bits, cnt / 16);
      chk("mids_9600", mids, (cnt + 8) / 16);

      // 3: rate change 7->0 with sample_index=5
      baud_select = 3'd7;
      step();
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step();
         if (sample_index == 4'd5) found = 1'b1;
      end
      chk("reach_idx5", found, 1);
      baud_select = 3'd0;
      step();
      chk("chg_idx", sample_index, 0);
      chk("chg_pulse", sample_ENABLE, 0);
      found = 1'b0; k = 0;
      for (int i = 1; i <= 12000 && !found; i++) begin
         step();
         if (sample_ENABLE) begin found = 1'b1; k = i; end
      end
      chk("first_300_tick", k, 10417);

      // 4: resync at a random phase, mid-bit 8 samples later
      baud_select = 3'd7;
      step();
      for (int r = 0; r < 3; r++) begin
         k = $urandom_range(0, 500);
         for (int i = 0; i < k; i++) step();
         resync = 1'b1;
         step();
         resync = 1'b0;
         chk("resync_pulse", sample_ENABLE, 0);
         chk("resync_idx", sample_index, 0);
         cnt = 0; found = 1'b0;
         for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (sample_ENABLE) cnt++;
            if (mid_bit_tick) found = 1'b1;
         end
         chk("resync_mid_samples", found ? cnt : -1, 8);
      end

      // 5: enable=0 for 100 clk freezes everything
      k = $urandom_range(5, 60);
      for (int i = 0; i < k; i++) step();
      idx_hold = sample_index;
      enable = 1'b0;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         pulses += sample_ENABLE + bit_tick + mid_bit_tick;
      end
      chk("pause_pulses", pulses, 0);
      chk("pause_idx", sample_index, idx_hold);
      enable = 1'b1;
      for (int i = 0; i < 200; i++) step();

      // 6: reset + resync + rate change together
      reset = 1'b1; resync = 1'b1; baud_select = 3'd2;
      step();
      chk("combo_outputs", {sample_ENABLE, bit_tick, mid_bit_tick, sample_index}, 0);
      reset = 1'b0; resync = 1'b0;

      // random traffic, biased towards the faster rates
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(0, 2999) == 0) begin
            sel_r = $urandom_range(0, 7);
            if (sel_r < 4 && $urandom_range(0, 3) != 0) sel_r = sel_r + 4;
            baud_select = 3'(sel_r);
         end
         enable = ($urandom_range(0, 9) != 0);
         resync = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
